// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared segment patterns, digit codes and digit-index encoding
package stopwatch_pkg;

  typedef logic [1:0] digitIdx_t;
  typedef logic [3:0] digitCode_t;

  localparam digitIdx_t DIGIT_MIN_TENS = 2'd3;
  localparam digitIdx_t DIGIT_MIN_ONES = 2'd2;
  localparam digitIdx_t DIGIT_SEC_TENS = 2'd1;
  localparam digitIdx_t DIGIT_SEC_ONES = 2'd0;

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_THREE = 7'b0110000;
  localparam logic [6:0] SEG_FOUR  = 7'b0011001;
  localparam logic [6:0] SEG_FIVE  = 7'b0010010;
  localparam logic [6:0] SEG_SIX   = 7'b0000010;
  localparam logic [6:0] SEG_SEVEN = 7'b1111000;
  localparam logic [6:0] SEG_EIGHT = 7'b0000000;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam digitCode_t CODE_DASH  = 4'd10;
  localparam digitCode_t CODE_BLANK = 4'd15;

  localparam logic [5:0] FIELD_LIMIT = 6'd60;

  function automatic digitCode_t tensOf(input logic [5:0] value);
    return 4'(value / 6'd10);
  endfunction

  function automatic digitCode_t onesOf(input logic [5:0] value);
    return 4'(value % 6'd10);
  endfunction

endpackage

// File: rtl/stopwatch_scan_driver_if.sv
// rtl/stopwatch_scan_driver_if.sv - time inputs, mode controls and display outputs of the scan driver
interface stopwatch_scan_driver_if;

  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       adj;
  logic       sel;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output minutes,
    output seconds,
    output adj,
    output sel,
    input  an,
    input  seg
  );

  modport slave (
    input  minutes,
    input  seconds,
    input  adj,
    input  sel,
    output an,
    output seg
  );

endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - 4-bit digit code to active-low seven-segment pattern
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  digitCode_t code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:      seg = SEG_ZERO;
      4'd1:      seg = SEG_ONE;
      4'd2:      seg = SEG_TWO;
      4'd3:      seg = SEG_THREE;
      4'd4:      seg = SEG_FOUR;
      4'd5:      seg = SEG_FIVE;
      4'd6:      seg = SEG_SIX;
      4'd7:      seg = SEG_SEVEN;
      4'd8:      seg = SEG_EIGHT;
      4'd9:      seg = SEG_NINE;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_scan_driver.sv
// rtl/stopwatch_scan_driver.sv - four-digit multiplexed MM:SS display driver with adjust-mode blink
module stopwatch_scan_driver
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   rst,
  stopwatch_scan_driver_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scanCnt;
  logic [BLINK_W-1:0] blinkCnt;
  logic               blinkOn;
  digitIdx_t          digitIdx;
  logic [5:0]         minShadow;
  logic [5:0]         secShadow;
  logic [3:0]         anReg;
  logic [6:0]         segReg;

  logic               slotTick;
  logic               frameStart;
  digitIdx_t          nextIdx;
  logic [5:0]         nextMin;
  logic [5:0]         nextSec;
  logic [5:0]         fieldValue;
  logic               minField;
  logic               fieldBlanked;
  digitCode_t         digitCode;
  logic [6:0]         digitSeg;

  assign slotTick   = (scanCnt == SCAN_W'(SCAN_DIV - 1));
  assign frameStart = slotTick && (digitIdx == DIGIT_SEC_ONES);
  assign nextIdx    = digitIdx - 2'd1;

  always_ff @(posedge clk) begin
    if (!rst)          scanCnt <= '0;
    else if (slotTick) scanCnt <= '0;
    else               scanCnt <= scanCnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)          digitIdx <= DIGIT_SEC_ONES;
    else if (slotTick) digitIdx <= nextIdx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      minShadow <= '0;
      secShadow <= '0;
    end else if (frameStart) begin
      minShadow <= bus.minutes;
      secShadow <= bus.seconds;
    end
  end

  // Holding the counter clear outside adjust mode makes every adj rise begin a full visible phase.
  always_ff @(posedge clk) begin
    if (!rst || !bus.adj) begin
      blinkCnt <= '0;
      blinkOn  <= 1'b1;
    end else if (blinkCnt == BLINK_W'(BLINK_DIV - 1)) begin
      blinkCnt <= '0;
      blinkOn  <= ~blinkOn;
    end else begin
      blinkCnt <= blinkCnt + 1'b1;
    end
  end

  // The digit being loaded on a frame-start tick must see the fresh sample, not the old shadow.
  always_comb begin
    nextMin      = frameStart ? bus.minutes : minShadow;
    nextSec      = frameStart ? bus.seconds : secShadow;
    minField     = nextIdx[1];
    fieldValue   = minField ? nextMin : nextSec;
    fieldBlanked = bus.adj && !blinkOn && (bus.sel == !minField);
    digitCode    = CODE_BLANK;
    if (fieldBlanked)                   digitCode = CODE_BLANK;
    else if (fieldValue >= FIELD_LIMIT) digitCode = CODE_DASH;
    else if (nextIdx[0])                digitCode = tensOf(fieldValue);
    else                                digitCode = onesOf(fieldValue);
  end

  seg7_decoder u_decoder (
    .code (digitCode),
    .seg  (digitSeg)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      anReg  <= 4'b1111;
      segReg <= SEG_BLANK;
    end else if (slotTick) begin
      anReg  <= ~(4'b0001 << nextIdx);
      segReg <= digitSeg;
    end
  end

  assign bus.an  = anReg;
  assign bus.seg = segReg;

endmodule

// File: tb/tb_stopwatch_scan_driver.sv
// tb/tb_stopwatch_scan_driver.sv - randomized scoreboard bench for stopwatch_scan_driver
module tb_stopwatch_scan_driver;

  localparam int SCAN  = 4;
  localparam int BLINK = 32;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stopwatch_scan_driver_if bus ();

  stopwatch_scan_driver #(
    .SCAN_DIV  (SCAN),
    .BLINK_DIV (BLINK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] segTab [10];
  logic [6:0] segDash;
  logic [6:0] segBlank;

  int    checks = 0;
  int    errors = 0;
  outs_t expQ[$];

  // Reference model: slot number from edges since reset, blink phase from consecutive adj edges.
  int         edgeCount;
  int         adjRun;
  int         shMin;
  int         shSec;
  int         slot;
  int         dig;
  int         val;
  bit         visible;
  bit         selected;
  logic [3:0] expAn;
  logic [6:0] expSeg;

  always @(posedge clk) begin
    if (!rst) begin
      edgeCount = 0;
      adjRun    = 0;
      shMin     = 0;
      shSec     = 0;
      expAn     = 4'b1111;
      expSeg    = segBlank;
    end else begin
      visible   = !bus.adj || (((adjRun / BLINK) % 2) == 0);
      edgeCount = edgeCount + 1;
      if ((edgeCount % SCAN) == 0) begin
        slot = edgeCount / SCAN;
        dig  = 3 - ((slot - 1) % 4);
        if (dig == 3) begin
          shMin = int'(bus.minutes);
          shSec = int'(bus.seconds);
        end
        expAn      = 4'b1111;
        expAn[dig] = 1'b0;
        val        = (dig >= 2) ? shMin : shSec;
        selected   = (dig >= 2) ? (bus.sel == 1'b0) : (bus.sel == 1'b1);
        if (bus.adj && !visible && selected) expSeg = segBlank;
        else if (val >= 60)                  expSeg = segDash;
        else if ((dig % 2) == 1)             expSeg = segTab[val / 10];
        else                                 expSeg = segTab[val % 10];
      end
      adjRun = bus.adj ? adjRun + 1 : 0;
    end
    expQ.push_back('{expAn, expSeg});
  end

  int failPrints = 0;
  outs_t got;

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      got    = expQ.pop_front();
      checks = checks + 1;
      if (bus.an !== got.an || bus.seg !== got.seg) begin
        errors = errors + 1;
        if (failPrints < 25) begin
          failPrints = failPrints + 1;
          $display("FAIL display t=%0t an=%b seg=%b required an=%b seg=%b",
                   $time, bus.an, bus.seg, got.an, got.seg);
        end
      end
    end
  end

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitAn(input logic [3:0] pattern, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.an !== pattern && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (bus.an !== pattern) begin
      errors = errors + 1;
      $display("FAIL %s timeout an=%b required an=%b", tag, bus.an, pattern);
    end
  endtask

  task automatic waitBlankSec(input int budget);
    int n;
    n = 0;
    while (!(bus.an[0] == 1'b0 && bus.seg === 7'b1111111) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (!(bus.an[0] == 1'b0 && bus.seg === 7'b1111111)) begin
      errors = errors + 1;
      $display("FAIL blank_phase timeout an=%b seg=%b required an=xxx0 seg=1111111", bus.an, bus.seg);
    end
  endtask

  initial begin
    segTab[0] = 7'b1000000;
    segTab[1] = 7'b1111001;
    segTab[2] = 7'b0100100;
    segTab[3] = 7'b0110000;
    segTab[4] = 7'b0011001;
    segTab[5] = 7'b0010010;
    segTab[6] = 7'b0000010;
    segTab[7] = 7'b1111000;
    segTab[8] = 7'b0000000;
    segTab[9] = 7'b0010000;
    segDash   = 7'b0111111;
    segBlank  = 7'b1111111;

    bus.minutes = 6'd12;
    bus.seconds = 6'd34;
    bus.adj     = 1'b0;
    bus.sel     = 1'b0;
    runCycles(3);
    rst = 1'b1;
    runCycles(40);

    waitAn(4'b1101, 40, "digit1_wait");
    bus.seconds = 6'd35;
    runCycles(40);

    bus.minutes = 6'd63;
    bus.seconds = 6'd0;
    runCycles(40);

    bus.minutes = 6'd5;
    bus.seconds = 6'd59;
    bus.sel     = 1'b1;
    bus.adj     = 1'b1;
    runCycles(200);

    waitBlankSec(200);
    bus.adj = 1'b0;
    runCycles(1);
    bus.adj = 1'b1;
    runCycles(120);

    runCycles(2);
    rst = 1'b0;
    runCycles(1);
    rst = 1'b1;
    runCycles(40);

    for (int i = 0; i < 40; i++) begin
      bus.minutes = 6'($urandom_range(0, 63));
      bus.seconds = 6'($urandom_range(0, 63));
      bus.adj     = 1'($urandom_range(0, 1));
      bus.sel     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b0;
        runCycles(1);
        rst = 1'b1;
      end
      runCycles($urandom_range(5, 75));
      if ($urandom_range(0, 2) == 0) bus.sel = ~bus.sel;
      runCycles($urandom_range(5, 75));
    end

    runCycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
